// File: rtl/adder_amba_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder_amba_pkg
// Brief    : Shared constants and state encoding for the adder AXI4-Lite
//            job sequencer (register map, control/status bits, FSM states).
// Revision : 1.0  initial release
// ============================================================================
package adder_amba_pkg;

  // Slave register map
  localparam logic [3:0] ADDR_R0   = 4'h0;
  localparam logic [3:0] ADDR_R1   = 4'h4;
  localparam logic [3:0] ADDR_R2   = 4'h8;
  localparam logic [3:0] ADDR_CTRL = 4'hC;

  // Control / status bit positions
  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_OP_BIT    = 1;
  localparam int STAT_DONE_BIT  = 31;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_R0   = 3'd1,
    S_WR_R1   = 3'd2,
    S_WR_CTRL = 3'd3,
    S_POLL    = 3'd4,
    S_RD_RES  = 3'd5,
    S_FINISH  = 3'd6
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/axil_single_master.sv
`default_nettype none
// ============================================================================
// Module   : axil_single_master
// Brief    : One-shot AXI4-Lite master. Accepts a single read or write
//            request, runs all channel handshakes and pulses o_done in the
//            cycle the B or R handshake completes, with rdata/resp valid then.
// Revision : 1.0  initial release
// ============================================================================
module axil_single_master
  import adder_amba_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_req,
  input  logic            i_req_write,
  input  logic [AW-1:0]   i_req_addr,
  input  logic [DW-1:0]   i_req_wdata,
  output logic            o_done,
  output logic [DW-1:0]   o_rdata,
  output logic [1:0]      o_resp,
  output logic [AW-1:0]   M_AXI_AWADDR,
  output logic [2:0]      M_AXI_AWPROT,
  output logic            M_AXI_AWVALID,
  input  logic            M_AXI_AWREADY,
  output logic [DW-1:0]   M_AXI_WDATA,
  output logic [DW/8-1:0] M_AXI_WSTRB,
  output logic            M_AXI_WVALID,
  input  logic            M_AXI_WREADY,
  input  logic [1:0]      M_AXI_BRESP,
  input  logic            M_AXI_BVALID,
  output logic            M_AXI_BREADY,
  output logic [AW-1:0]   M_AXI_ARADDR,
  output logic [2:0]      M_AXI_ARPROT,
  output logic            M_AXI_ARVALID,
  input  logic            M_AXI_ARREADY,
  input  logic [DW-1:0]   M_AXI_RDATA,
  input  logic [1:0]      M_AXI_RRESP,
  input  logic            M_AXI_RVALID,
  output logic            M_AXI_RREADY
);

  logic          r_awvalid;
  logic          r_wvalid;
  logic          r_bready;
  logic          r_wr_active;
  logic          r_arvalid;
  logic          r_rready;
  logic [AW-1:0] r_awaddr;
  logic [DW-1:0] r_wdata;
  logic [AW-1:0] r_araddr;

  // Channel handshake tracking; a new request is applied last so it wins
  // over the completion clears of the transaction ending on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_wr_active <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_awaddr    <= '0;
      r_wdata     <= '0;
      r_araddr    <= '0;
    end else begin
      if (r_awvalid && M_AXI_AWREADY) r_awvalid <= 1'b0;
      if (r_wvalid && M_AXI_WREADY) r_wvalid <= 1'b0;
      // BREADY only once both AW and W have been accepted
      if (r_wr_active && !r_awvalid && !r_wvalid && !r_bready) r_bready <= 1'b1;
      if (r_bready && M_AXI_BVALID) begin
        r_bready    <= 1'b0;
        r_wr_active <= 1'b0;
      end
      if (r_arvalid && M_AXI_ARREADY) begin
        r_arvalid <= 1'b0;
        r_rready  <= 1'b1;
      end
      if (r_rready && M_AXI_RVALID) r_rready <= 1'b0;
      if (i_req && i_req_write) begin
        r_awvalid   <= 1'b1;
        r_wvalid    <= 1'b1;
        r_wr_active <= 1'b1;
        r_awaddr    <= i_req_addr;
        r_wdata     <= i_req_wdata;
      end else if (i_req) begin
        r_arvalid <= 1'b1;
        r_araddr  <= i_req_addr;
      end
    end
  end

  assign o_done  = (r_bready && M_AXI_BVALID) || (r_rready && M_AXI_RVALID);
  assign o_resp  = r_rready ? M_AXI_RRESP : M_AXI_BRESP;
  assign o_rdata = M_AXI_RDATA;

  assign M_AXI_AWADDR  = r_awaddr;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = r_bready;
  assign M_AXI_ARADDR  = r_araddr;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_RREADY  = r_rready;

endmodule
`default_nettype wire

// File: rtl/adder_amba_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : adder_amba_sequencer
// Brief    : Runs one add/sub job on the adder's AXI4-Lite slave: writes
//            operands and start, polls the done flag, reads the result.
// Revision : 1.0  initial release
// ============================================================================
module adder_amba_sequencer
  import adder_amba_pkg::*;
#(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter int C_POLL_MAX         = 16
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic                            i_start,
  input  logic                            i_op,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   i_a,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   i_b,
  output logic                            o_busy,
  output logic                            o_done,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   o_result,
  output logic                            o_err,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int CW = $clog2(C_POLL_MAX + 1);

  seq_state_t    r_state;
  seq_state_t    w_next;
  logic          r_op;
  logic [DW-1:0] r_b;
  logic [DW-1:0] r_result;
  logic          r_err;
  logic [CW-1:0] r_poll_cnt;

  logic          w_req;
  logic          w_req_write;
  logic [AW-1:0] w_req_addr;
  logic [DW-1:0] w_req_wdata;
  logic [DW-1:0] w_ctrl_word;
  logic          w_set_err;
  logic          w_load_result;
  logic          w_poll_inc;
  logic          w_poll_clr;
  logic          w_m_done;
  logic [DW-1:0] w_m_rdata;
  logic [1:0]    w_m_resp;
  logic          w_resp_ok;

  assign w_resp_ok = (w_m_resp == RESP_OKAY);

  // Control word that launches the slave: start bit plus operation select
  always_comb begin
    w_ctrl_word                 = '0;
    w_ctrl_word[CTRL_START_BIT] = 1'b1;
    w_ctrl_word[CTRL_OP_BIT]    = r_op;
  end

  // Job state register
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) r_state <= S_IDLE;
    else                r_state <= w_next;
  end

  // Next state; each bus request is issued on the edge that enters its state
  always_comb begin
    w_next        = r_state;
    w_req         = 1'b0;
    w_req_write   = 1'b0;
    w_req_addr    = '0;
    w_req_wdata   = '0;
    w_set_err     = 1'b0;
    w_load_result = 1'b0;
    w_poll_inc    = 1'b0;
    w_poll_clr    = 1'b0;
    case (r_state)
      S_IDLE: if (i_start) begin
        w_next      = S_WR_R0;
        w_req       = 1'b1;
        w_req_write = 1'b1;
        w_req_addr  = AW'(ADDR_R0);
        w_req_wdata = i_a;
      end
      S_WR_R0: if (w_m_done) begin
        if (!w_resp_ok) begin
          w_next    = S_FINISH;
          w_set_err = 1'b1;
        end else begin
          w_next      = S_WR_R1;
          w_req       = 1'b1;
          w_req_write = 1'b1;
          w_req_addr  = AW'(ADDR_R1);
          w_req_wdata = r_b;
        end
      end
      S_WR_R1: if (w_m_done) begin
        if (!w_resp_ok) begin
          w_next    = S_FINISH;
          w_set_err = 1'b1;
        end else begin
          w_next      = S_WR_CTRL;
          w_req       = 1'b1;
          w_req_write = 1'b1;
          w_req_addr  = AW'(ADDR_CTRL);
          w_req_wdata = w_ctrl_word;
        end
      end
      S_WR_CTRL: if (w_m_done) begin
        if (!w_resp_ok) begin
          w_next    = S_FINISH;
          w_set_err = 1'b1;
        end else begin
          w_next     = S_POLL;
          w_req      = 1'b1;
          w_req_addr = AW'(ADDR_CTRL);
          w_poll_clr = 1'b1;
        end
      end
      S_POLL: if (w_m_done) begin
        if (!w_resp_ok) begin
          w_next    = S_FINISH;
          w_set_err = 1'b1;
        end else if (w_m_rdata[STAT_DONE_BIT]) begin
          w_next     = S_RD_RES;
          w_req      = 1'b1;
          w_req_addr = AW'(ADDR_R2);
        end else if (r_poll_cnt == CW'(C_POLL_MAX - 1)) begin
          // this was the last permitted status read
          w_next    = S_FINISH;
          w_set_err = 1'b1;
        end else begin
          w_req      = 1'b1;
          w_req_addr = AW'(ADDR_CTRL);
          w_poll_inc = 1'b1;
        end
      end
      S_RD_RES: if (w_m_done) begin
        w_next = S_FINISH;
        if (!w_resp_ok) w_set_err = 1'b1;
        else            w_load_result = 1'b1;
      end
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Job datapath: latched operands, error flag, result and poll counter
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_op       <= 1'b0;
      r_b        <= '0;
      r_err      <= 1'b0;
      r_result   <= '0;
      r_poll_cnt <= '0;
    end else begin
      if (r_state == S_IDLE && i_start) begin
        r_op  <= i_op;
        r_b   <= i_b;
        r_err <= 1'b0;
      end
      if (w_set_err)     r_err    <= 1'b1;
      if (w_load_result) r_result <= w_m_rdata;
      if (w_poll_clr)      r_poll_cnt <= '0;
      else if (w_poll_inc) r_poll_cnt <= r_poll_cnt + CW'(1);
    end
  end

  assign o_busy   = (r_state != S_IDLE) && (r_state != S_FINISH);
  assign o_done   = (r_state == S_FINISH);
  assign o_err    = r_err && (r_state == S_FINISH);
  assign o_result = r_result;

  axil_single_master #(
    .DW (DW),
    .AW (AW)
  ) u_master (
    .clk           (S_AXI_ACLK),
    .rst_n         (S_AXI_ARESETN),
    .i_req         (w_req),
    .i_req_write   (w_req_write),
    .i_req_addr    (w_req_addr),
    .i_req_wdata   (w_req_wdata),
    .o_done        (w_m_done),
    .o_rdata       (w_m_rdata),
    .o_resp        (w_m_resp),
    .M_AXI_AWADDR  (M_AXI_AWADDR),
    .M_AXI_AWPROT  (M_AXI_AWPROT),
    .M_AXI_AWVALID (M_AXI_AWVALID),
    .M_AXI_AWREADY (M_AXI_AWREADY),
    .M_AXI_WDATA   (M_AXI_WDATA),
    .M_AXI_WSTRB   (M_AXI_WSTRB),
    .M_AXI_WVALID  (M_AXI_WVALID),
    .M_AXI_WREADY  (M_AXI_WREADY),
    .M_AXI_BRESP   (M_AXI_BRESP),
    .M_AXI_BVALID  (M_AXI_BVALID),
    .M_AXI_BREADY  (M_AXI_BREADY),
    .M_AXI_ARADDR  (M_AXI_ARADDR),
    .M_AXI_ARPROT  (M_AXI_ARPROT),
    .M_AXI_ARVALID (M_AXI_ARVALID),
    .M_AXI_ARREADY (M_AXI_ARREADY),
    .M_AXI_RDATA   (M_AXI_RDATA),
    .M_AXI_RRESP   (M_AXI_RRESP),
    .M_AXI_RVALID  (M_AXI_RVALID),
    .M_AXI_RREADY  (M_AXI_RREADY)
  );

endmodule
`default_nettype wire
